// File: rtl/lm75_i2c_slave.sv
// lm75_i2c_slave: LM75-compatible I2C target. Scl/Sda are oversampled on Clk_in; Sda is
// driven open-drain through Sda_oe. Define LM75_OS_EN to compile in the Os comparator;
// without it Os is tied high and config bits are only stored.
module lm75_i2c_slave #(
  parameter logic [6:0] SLV_ADR = 7'h48
) (
  input  logic       Clk_in,
  input  logic       Rst,
  input  logic       Scl_in,
  input  logic       Sda_in,
  output logic       Sda_oe,
  input  logic [8:0] Temp,
  input  logic       Temp_vld,
  output logic       Busy,
  output logic       Os
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAAck, StPtr, StPAck, StWr, StWAck, StRd, StRAck
  } state_e;

  state_e      state_q, state_d;
  logic  [1:0] scl_sync_q, sda_sync_q;
  logic        scl_prev_q, sda_prev_q;
  logic        scl, sda, scl_rise, scl_fall, start_det, stop_det;
  logic  [3:0] cnt_q, cnt_d;
  logic  [7:0] shift_q, shift_d, tx_q, tx_d, msb_hold_q, msb_hold_d, rd_byte;
  logic  [7:0] config_q, config_d;
  logic  [8:0] temp_snap_q, temp_snap_d, thyst_q, thyst_d, tos_q, tos_d;
  logic  [1:0] ptr_q, ptr_d, widx_q, widx_d;
  logic        rw_q, rw_d, mack_q, mack_d, ridx_q, ridx_d, busy_q, busy_d;
  logic        addr_hit, ptr_ok, wr_ack, load_tx;

  // Two-flop synchronizers plus one delay flop for edge detection; bus idles high
  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], Scl_in};
      sda_sync_q <= {sda_sync_q[0], Sda_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl       = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  = scl && !scl_prev_q;
  assign scl_fall  = !scl && scl_prev_q;
  assign start_det = scl && scl_prev_q && sda_prev_q && !sda;
  assign stop_det  = scl && scl_prev_q && !sda_prev_q && sda;

  // State register
  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state: START/STOP override everything; byte phases advance on Scl fall
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = StAddr;
    end else if (stop_det) begin
      state_d = StIdle;
    end else if (scl_fall) begin
      case (state_q)
        StAddr: if (cnt_q == 4'd8) state_d = (shift_q[7:1] == SLV_ADR) ? StAAck : StIdle;
        StAAck: if (cnt_q == 4'd9) state_d = rw_q ? StRd : StPtr;
        StPtr:  if (cnt_q == 4'd8) state_d = (shift_q[7:2] != 6'd0) ? StIdle : StPAck;
        StPAck: if (cnt_q == 4'd9) state_d = StWr;
        StWr:   if (cnt_q == 4'd8) state_d = StWAck;
        StWAck: if (cnt_q == 4'd9) state_d = StWr;
        StRd:   if (cnt_q == 4'd8) state_d = StRAck;
        StRAck: if (cnt_q == 4'd9) state_d = mack_q ? StRd : StIdle;
        default: ;
      endcase
    end
  end

  // Outputs: ACK phases pull low, read phase drives the current tx bit
  always_comb begin
    Sda_oe = 1'b0;
    Busy   = busy_q;
    case (state_q)
      StAAck, StPAck, StWAck: Sda_oe = 1'b1;
      StRd:                   Sda_oe = !tx_q[7];
      default: ;
    endcase
  end

  assign addr_hit = (state_q == StAddr) && (state_d == StAAck);
  assign ptr_ok   = (state_q == StPtr) && (state_d == StPAck);
  assign wr_ack   = (state_q == StWr) && (state_d == StWAck);
  assign load_tx  = (state_d == StRd) && ((state_q == StAAck) || (state_q == StRAck));

  // Read byte mux: 9-bit registers alternate MSB / {bit0, 7'b0}
  always_comb begin
    rd_byte = 8'h00;
    case (ptr_q)
      2'b00:   rd_byte = ridx_q ? {temp_snap_q[0], 7'b0} : temp_snap_q[8:1];
      2'b01:   rd_byte = config_q;
      2'b10:   rd_byte = ridx_q ? {thyst_q[0], 7'b0} : thyst_q[8:1];
      default: rd_byte = ridx_q ? {tos_q[0], 7'b0} : tos_q[8:1];
    endcase
  end

  // Datapath next-state: bit counter, shifters, pointer and register writes
  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    ridx_d      = ridx_q;
    widx_d      = widx_q;
    ptr_d       = ptr_q;
    temp_snap_d = temp_snap_q;
    msb_hold_d  = msb_hold_q;
    config_d    = config_q;
    thyst_d     = thyst_q;
    tos_d       = tos_q;
    busy_d      = busy_q;
    if (start_det || stop_det)                    cnt_d = 4'd0;
    else if (scl_rise && state_q != StIdle)       cnt_d = cnt_q + 4'd1;
    else if (scl_fall && cnt_q == 4'd9)           cnt_d = 4'd0;
    if (scl_rise && cnt_q < 4'd8 &&
        (state_q == StAddr || state_q == StPtr || state_q == StWr)) begin
      shift_d = {shift_q[6:0], sda};
    end
    if (scl_rise && state_q == StRAck) mack_d = !sda;
    if (addr_hit) begin
      rw_d        = shift_q[0];
      ridx_d      = 1'b0;
      temp_snap_d = Temp;
    end
    if (load_tx) begin
      tx_d   = rd_byte;
      ridx_d = !ridx_q;
    end else if (scl_fall && state_q == StRd && cnt_q != 4'd0 && cnt_q < 4'd8) begin
      tx_d = {tx_q[6:0], 1'b1};
    end
    if (ptr_ok) begin
      ptr_d  = shift_q[1:0];
      widx_d = 2'd0;
    end
    if (wr_ack) begin
      widx_d = (widx_q == 2'd2) ? 2'd2 : widx_q + 2'd1;
      case (ptr_q)
        2'b01: if (widx_q == 2'd0) config_d = shift_q;
        2'b10: begin
          if (widx_q == 2'd0) msb_hold_d = shift_q;
          if (widx_q == 2'd1) thyst_d = {msb_hold_q, shift_q[7]};
        end
        2'b11: begin
          if (widx_q == 2'd0) msb_hold_d = shift_q;
          if (widx_q == 2'd1) tos_d = {msb_hold_q, shift_q[7]};
        end
        default: ;
      endcase
    end
    if (state_d == StIdle) busy_d = 1'b0;
    else if (addr_hit)     busy_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'hFF;
      rw_q        <= 1'b0;
      mack_q      <= 1'b0;
      ridx_q      <= 1'b0;
      widx_q      <= 2'd0;
      ptr_q       <= 2'b00;
      temp_snap_q <= 9'h000;
      msb_hold_q  <= 8'h00;
      config_q    <= 8'h00;
      thyst_q     <= 9'h096;
      tos_q       <= 9'h0A0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      ridx_q      <= ridx_d;
      widx_q      <= widx_d;
      ptr_q       <= ptr_d;
      temp_snap_q <= temp_snap_d;
      msb_hold_q  <= msb_hold_d;
      config_q    <= config_d;
      thyst_q     <= thyst_d;
      tos_q       <= tos_d;
      busy_q      <= busy_d;
    end
  end

`ifdef LM75_OS_EN
  logic       os_state_q, os_state_d;
  logic [2:0] fault_q, fault_d, fault_thr, fault_inc;

  // Os comparator: fault queue against Tos, hysteresis release below Thyst
  always_comb begin
    os_state_d = os_state_q;
    fault_d    = fault_q;
    case (config_q[4:3])
      2'b00:   fault_thr = 3'd1;
      2'b01:   fault_thr = 3'd2;
      2'b10:   fault_thr = 3'd4;
      default: fault_thr = 3'd6;
    endcase
    fault_inc = (fault_q >= fault_thr) ? fault_q : fault_q + 3'd1;
    if (Temp_vld && !config_q[0]) begin
      if ($signed(Temp) >= $signed(tos_q)) begin
        fault_d = fault_inc;
        if (fault_inc >= fault_thr) os_state_d = 1'b1;
      end else begin
        fault_d = 3'd0;
        if ($signed(Temp) < $signed(thyst_q)) os_state_d = 1'b0;
      end
    end
  end

  // Comparator state
  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      os_state_q <= 1'b0;
      fault_q    <= 3'd0;
    end else begin
      os_state_q <= os_state_d;
      fault_q    <= fault_d;
    end
  end

  assign Os = config_q[2] ? os_state_q : !os_state_q;
`else
  logic unused_temp_vld;
  assign unused_temp_vld = Temp_vld;
  assign Os              = 1'b1;
`endif

endmodule

// File: tb/tb_lm75_i2c_slave.sv
// Directed bench for lm75_i2c_slave: an I2C master model drives Scl/Sda with the
// open-drain bus resolved against the DUT's Sda_oe.
module tb_lm75_i2c_slave;

  localparam int Q = 200;  // quarter Scl period in ns (10 Clk_in cycles)

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_oe, busy, os;
  logic [8:0] temp;
  logic       temp_vld;
  logic       sda_line;
  int         total = 0;
  int         bad = 0;

  assign sda_line = sda_m & ~sda_oe;

  always #10 clk = ~clk;

  lm75_i2c_slave dut (
    .Clk_in  (clk),
    .Rst     (rst),
    .Scl_in  (scl_m),
    .Sda_in  (sda_line),
    .Sda_oe  (sda_oe),
    .Temp    (temp),
    .Temp_vld(temp_vld),
    .Busy    (busy),
    .Os      (os)
  );

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2 * Q); scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack, output logic oe_at_ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    ack = ~sda_line;
    oe_at_ack = sda_oe;
    #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
      b[i] = sda_line;
      #Q; scl_m = 1'b0; #Q;
    end
    sda_m = ~mack; #Q; scl_m = 1'b1; #(2 * Q); scl_m = 1'b0; #Q;
  endtask

  task automatic set_ptr(input logic [7:0] p);
    logic a, o;
    i2c_start(); write_byte(8'h90, a, o); write_byte(p, a, o); i2c_stop();
  endtask

  task automatic strobe_temp(input logic [8:0] t);
    temp = t; temp_vld = 1'b1; #20; temp_vld = 1'b0; #40;
  endtask

  task automatic test_reset();
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (os !== 1'b1) begin bad++; $display("FAIL reset_os got=%b want=1", os); end
  endtask

  task automatic test_config_rw();
    logic a, o;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h90, a, o);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL cfg_addr_ack got=%b want=1", a); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cfg_busy_mid got=%b want=1", busy); end
    write_byte(8'h01, a, o);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL cfg_ptr_ack got=%b want=1", a); end
    write_byte(8'h1A, a, o);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL cfg_data_ack got=%b want=1", a); end
    i2c_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cfg_busy_stop got=%b want=0", busy); end
    i2c_start();
    write_byte(8'h91, a, o);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL cfg_rd_ack got=%b want=1", a); end
    read_byte(1'b1, d);
    total++; if (d !== 8'h1A) begin bad++; $display("FAIL cfg_rd0 got=%h want=1a", d); end
    read_byte(1'b0, d);
    total++; if (d !== 8'h1A) begin bad++; $display("FAIL cfg_rd1 got=%h want=1a", d); end
    i2c_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cfg_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_temp_read();
    logic a, o;
    logic [7:0] d;
    temp = 9'h1CE;
    set_ptr(8'h00);
    i2c_start();
    write_byte(8'h91, a, o);
    temp = 9'h0A0;  // changed after the snapshot point
    read_byte(1'b1, d);
    total++; if (d !== 8'hE7) begin bad++; $display("FAIL temp_msb got=%h want=e7", d); end
    read_byte(1'b0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL temp_lsb got=%h want=00", d); end
    i2c_stop();
    i2c_start();
    write_byte(8'h91, a, o);
    read_byte(1'b1, d);
    total++; if (d !== 8'h50) begin bad++; $display("FAIL temp_new_msb got=%h want=50", d); end
    read_byte(1'b0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL temp_new_lsb got=%h want=00", d); end
    i2c_stop();
    temp = 9'h1FF;  // -0.5 C, LSB set
    i2c_start();
    write_byte(8'h91, a, o);
    read_byte(1'b1, d);
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL temp_neg_msb got=%h want=ff", d); end
    read_byte(1'b0, d);
    total++; if (d !== 8'h80) begin bad++; $display("FAIL temp_neg_lsb got=%h want=80", d); end
    i2c_stop();
  endtask

  task automatic test_stop_abort();
    logic a, o;
    logic [7:0] d;
    i2c_start(); write_byte(8'h90, a, o); write_byte(8'h03, a, o); write_byte(8'h12, a, o);
    i2c_stop();
    i2c_start();
    write_byte(8'h91, a, o);
    read_byte(1'b1, d);
    total++; if (d !== 8'h50) begin bad++; $display("FAIL abort_tos_msb got=%h want=50", d); end
    read_byte(1'b0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL abort_tos_lsb got=%h want=00", d); end
    i2c_stop();
  endtask

  task automatic test_tos_write();
    logic a, o;
    logic [7:0] d;
    i2c_start(); write_byte(8'h90, a, o); write_byte(8'h03, a, o);
    write_byte(8'h55, a, o); write_byte(8'h80, a, o);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL tos_lsb_ack got=%b want=1", a); end
    write_byte(8'h00, a, o);  // extra byte: acked, ignored
    total++; if (a !== 1'b1) begin bad++; $display("FAIL tos_extra_ack got=%b want=1", a); end
    i2c_stop();
    i2c_start();
    write_byte(8'h91, a, o);
    read_byte(1'b1, d);
    total++; if (d !== 8'h55) begin bad++; $display("FAIL tos_rd0 got=%h want=55", d); end
    read_byte(1'b1, d);
    total++; if (d !== 8'h80) begin bad++; $display("FAIL tos_rd1 got=%h want=80", d); end
    read_byte(1'b0, d);
    total++; if (d !== 8'h55) begin bad++; $display("FAIL tos_rd2 got=%h want=55", d); end
    i2c_stop();
  endtask

  task automatic test_addr_mismatch();
    logic a, o;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h92, a, o);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL miss_ack got=%b want=0", a); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL miss_oe got=%b want=0", o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL miss_busy got=%b want=0", busy); end
    i2c_stop();
    i2c_start();
    write_byte(8'h90, a, o);
    write_byte(8'h04, a, o);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL badptr_ack got=%b want=0", a); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL badptr_busy got=%b want=0", busy); end
    i2c_stop();
    i2c_start();
    write_byte(8'h91, a, o);
    read_byte(1'b0, d);
    total++; if (d !== 8'h55) begin bad++; $display("FAIL ptr_kept got=%h want=55", d); end
    i2c_stop();
  endtask

  task automatic test_os();
    logic a, o;
    logic [7:0] d;
    logic       exp_os2;
`ifdef LM75_OS_EN
    exp_os2 = 1'b0;
`else
    exp_os2 = 1'b1;
`endif
    i2c_start(); write_byte(8'h90, a, o); write_byte(8'h03, a, o);
    write_byte(8'h50, a, o); write_byte(8'h00, a, o); i2c_stop();
    i2c_start(); write_byte(8'h90, a, o); write_byte(8'h01, a, o); write_byte(8'h08, a, o);
    i2c_stop();
    i2c_start(); write_byte(8'h91, a, o); read_byte(1'b0, d); i2c_stop();
    total++; if (d !== 8'h08) begin bad++; $display("FAIL os_cfg_rd got=%h want=08", d); end
    strobe_temp(9'h0A0);
    total++; if (os !== 1'b1) begin bad++; $display("FAIL os_one_fault got=%b want=1", os); end
    strobe_temp(9'h0A0);
    total++; if (os !== exp_os2) begin bad++; $display("FAIL os_two_fault got=%b want=%b", os, exp_os2); end
    strobe_temp(9'h095);
    total++; if (os !== 1'b1) begin bad++; $display("FAIL os_clear got=%b want=1", os); end
  endtask

  task automatic test_reset_mid_ack();
    logic a, o;
    logic [7:0] d;
    logic [7:0] adr;
    adr = 8'h90;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(adr[i]);
    total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rst_ack_on got=%b want=1", sda_oe); end
    rst = 1'b1;
    #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_async_oe got=%b want=0", sda_oe); end
    #19;
    scl_m = 1'b1; sda_m = 1'b1;
    #100;
    rst = 1'b0;
    #Q;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    set_ptr(8'h03);
    i2c_start(); write_byte(8'h91, a, o); read_byte(1'b0, d); i2c_stop();
    total++; if (d !== 8'h50) begin bad++; $display("FAIL rst_tos got=%h want=50", d); end
    set_ptr(8'h01);
    i2c_start(); write_byte(8'h91, a, o); read_byte(1'b0, d); i2c_stop();
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_cfg got=%h want=00", d); end
  endtask

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; temp = 9'h000; temp_vld = 1'b0;
    #60;
    test_reset();
    #40;
    rst = 1'b0;
    #Q;
    test_config_rw();
    test_temp_read();
    test_stop_abort();
    test_tos_write();
    test_addr_mismatch();
    test_os();
    test_reset_mid_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
